// File: rtl/dbg_abstract_cmd_ctrl.sv
// rtl/dbg_abstract_cmd_ctrl.sv - RISC-V debug Access Register abstract command sequencer
module dbg_abstract_cmd_ctrl #(
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [15:0] GPR_BASE   = 16'h1000,
  parameter logic [15:0] CSR_DCSR   = 16'h07b0,
  parameter logic [15:0] CSR_DPC    = 16'h07b1
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        cmd_valid_i,
  input  logic [31:0] cmd_i,
  input  logic [31:0] data0_i,
  output logic [31:0] data0_o,
  output logic        data0_we_o,
  input  logic        cmderr_clr_i,
  output logic        busy_o,
  output logic [2:0]  cmderr_o,
  input  logic        core_halted_i,
  output logic        ar_en_o,
  output logic        ar_wr_o,
  output logic [15:0] ar_ad_o,
  output logic [31:0] ar_do_o,
  input  logic [31:0] ar_di_i
);

  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, CAPTURE, DONE} state_e;

  localparam logic [2:0] WAIT_INIT = 3'(RD_LATENCY - 1);

  state_e      state;
  logic [2:0]  wait_cnt;
  logic [2:0]  cmderr_base;
  logic [15:0] regno;
  logic [15:0] gpr_off;
  logic        transfer;
  logic        unsupported;
  logic        regno_ok;
  logic        unused_cmd_bits;

  assign regno       = cmd_i[15:0];
  assign transfer    = cmd_i[17];
  assign gpr_off     = regno - GPR_BASE;
  assign regno_ok    = ((regno >= GPR_BASE) && (gpr_off < 16'd32)) ||
                       (regno == CSR_DCSR) || (regno == CSR_DPC);
  assign unsupported = (cmd_i[31:24] != 8'd0) || cmd_i[18] ||
                       (transfer && (cmd_i[22:20] != 3'd2));
  assign unused_cmd_bits = cmd_i[23] ^ cmd_i[19];

  // A clear in the same cycle is applied before any new error is recorded.
  assign cmderr_base = cmderr_clr_i ? 3'd0 : cmderr_o;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state      <= IDLE;
      wait_cnt   <= 3'd0;
      busy_o     <= 1'b0;
      cmderr_o   <= 3'd0;
      data0_o    <= 32'd0;
      data0_we_o <= 1'b0;
      ar_en_o    <= 1'b0;
      ar_wr_o    <= 1'b0;
      ar_ad_o    <= 16'd0;
      ar_do_o    <= 32'd0;
    end else begin
      data0_we_o <= 1'b0;
      cmderr_o   <= cmderr_base;
      if ((state != IDLE) && cmd_valid_i && (cmderr_base == 3'd0)) begin
        cmderr_o <= 3'd1;
      end

      case (state)
        IDLE: begin
          if (cmd_valid_i && (cmderr_base == 3'd0)) begin
            busy_o <= 1'b1;
            state  <= DONE;
            if (unsupported) begin
              cmderr_o <= 3'd2;
            end else if (!core_halted_i) begin
              cmderr_o <= 3'd4;
            end else if (transfer && !regno_ok) begin
              cmderr_o <= 3'd3;
            end else if (transfer) begin
              state   <= ACCESS;
              ar_en_o <= 1'b1;
              ar_wr_o <= cmd_i[16];
              ar_ad_o <= regno;
              ar_do_o <= data0_i;
            end
          end
        end

        ACCESS: begin
          ar_en_o  <= 1'b0;
          ar_wr_o  <= 1'b0;
          ar_ad_o  <= 16'd0;
          ar_do_o  <= 32'd0;
          wait_cnt <= WAIT_INIT;
          if (!core_halted_i) begin
            cmderr_o <= 3'd4;
            state    <= DONE;
          end else if (ar_wr_o) begin
            state <= DONE;
          end else if (WAIT_INIT == 3'd0) begin
            state <= CAPTURE;
          end else begin
            state <= WAIT;
          end
        end

        WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (!core_halted_i) begin
            cmderr_o <= 3'd4;
            state    <= DONE;
          end else if (wait_cnt == 3'd1) begin
            state <= CAPTURE;
          end
        end

        CAPTURE: begin
          state <= DONE;
          if (!core_halted_i) begin
            cmderr_o <= 3'd4;
          end else begin
            data0_o    <= ar_di_i;
            data0_we_o <= 1'b1;
          end
        end

        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_abstract_cmd_ctrl.sv
// tb/tb_dbg_abstract_cmd_ctrl.sv - timeline reference model bench for dbg_abstract_cmd_ctrl
module tb_dbg_abstract_cmd_ctrl;

  localparam int L = 2;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic [31:0] cmd_i = 32'd0;
  logic [31:0] data0_i = 32'd0;
  logic [31:0] data0_o;
  logic        data0_we_o;
  logic        cmderr_clr_i = 1'b0;
  logic        busy_o;
  logic [2:0]  cmderr_o;
  logic        core_halted_i = 1'b1;
  logic        ar_en_o;
  logic        ar_wr_o;
  logic [15:0] ar_ad_o;
  logic [31:0] ar_do_o;
  logic [31:0] ar_di_i = 32'd0;

  int total = 0;
  int bad = 0;
  bit chk_on = 0;

  dbg_abstract_cmd_ctrl #(.RD_LATENCY(L)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .cmd_valid_i(cmd_valid_i), .cmd_i(cmd_i),
    .data0_i(data0_i), .data0_o(data0_o), .data0_we_o(data0_we_o),
    .cmderr_clr_i(cmderr_clr_i), .busy_o(busy_o), .cmderr_o(cmderr_o),
    .core_halted_i(core_halted_i), .ar_en_o(ar_en_o), .ar_wr_o(ar_wr_o),
    .ar_ad_o(ar_ad_o), .ar_do_o(ar_do_o), .ar_di_i(ar_di_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each accepted command is turned into a timeline of cycle numbers.
  int          cyc = 0;
  int          busy_start = 1, busy_end = 0;
  int          acc_cyc = -1, cap_cyc = -1;
  bit          act = 0, act_wr = 0;
  logic        a_wr = 0;
  logic [15:0] a_ad = 0;
  logic [31:0] a_do = 0;
  logic [2:0]  m_err = 0;
  logic        m_busy = 0, m_en = 0, m_wr = 0, m_we = 0;
  logic [15:0] m_ad = 0;
  logic [31:0] m_do = 0, m_data = 0;

  function automatic bit reg_ok(input logic [15:0] r);
    return ((r >= 16'h1000) && (r <= 16'h101f)) || (r == 16'h07b0) || (r == 16'h07b1);
  endfunction

  function automatic logic [2:0] classify(input logic [31:0] c, input logic halted);
    if ((c[31:24] != 0) || c[18] || (c[17] && (c[22:20] != 3'd2))) return 3'd2;
    if (!halted) return 3'd4;
    if (c[17] && !reg_ok(c[15:0])) return 3'd3;
    return 3'd0;
  endfunction

  always @(posedge clk_i or negedge reset_ni) begin : model
    int k, p;
    bit pb;
    logic [2:0] e;
    if (!reset_ni) begin
      busy_start = 1; busy_end = 0; acc_cyc = -1; cap_cyc = -1; act = 0;
      m_err = 0; m_busy = 0; m_en = 0; m_wr = 0; m_ad = 0; m_do = 0; m_we = 0; m_data = 0;
    end else begin
      cyc++;
      k = cyc;
      p = k - 1;
      pb = (p >= busy_start) && (p <= busy_end);
      e = cmderr_clr_i ? 3'd0 : m_err;
      if (cmd_valid_i && pb && (e == 0)) e = 3'd1;
      if (act && !core_halted_i) begin
        e = 3'd4; act = 0; busy_end = k;
      end
      m_we = 0;
      if (act && !act_wr && (p == cap_cyc)) begin
        m_we = 1; m_data = ar_di_i; act = 0;
      end else if (act && act_wr && (p == acc_cyc)) begin
        act = 0;
      end
      if (cmd_valid_i && !pb && (e == 0)) begin
        e = classify(cmd_i, core_halted_i);
        busy_start = k;
        busy_end = k;
        if ((e == 0) && cmd_i[17]) begin
          act = 1; act_wr = cmd_i[16]; acc_cyc = k; cap_cyc = k + L;
          busy_end = cmd_i[16] ? k + 1 : k + L + 1;
          a_wr = cmd_i[16]; a_ad = cmd_i[15:0]; a_do = data0_i;
        end
      end
      m_err  = e;
      m_busy = (k >= busy_start) && (k <= busy_end);
      m_en   = act && (k == acc_cyc);
      m_wr   = m_en ? a_wr : 1'b0;
      m_ad   = m_en ? a_ad : 16'd0;
      m_do   = m_en ? a_do : 32'd0;
    end
  end

  always @(negedge clk_i) begin
    if (chk_on) begin
      chk("busy", busy_o, m_busy);
      chk("cmderr", cmderr_o, m_err);
      chk("ar_en", ar_en_o, m_en);
      chk("ar_wr", ar_wr_o, m_wr);
      chk("ar_ad", ar_ad_o, m_ad);
      chk("ar_do", ar_do_o, m_do);
      chk("data0_we", data0_we_o, m_we);
      if (m_we) chk("data0", data0_o, m_data);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    cmderr_clr_i = 1'b0;
  endtask

  task automatic issue(input logic [31:0] c, input logic [31:0] d0);
    cmd_i = c;
    data0_i = d0;
    cmd_valid_i = 1'b1;
    tick();
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (busy_o && (i < 20)) begin
      tick();
      i++;
    end
    chk("idle_timeout", busy_o, 0);
  endtask

  task automatic clear_err();
    cmderr_clr_i = 1'b1;
    tick();
  endtask

  function automatic logic [31:0] rand_cmd();
    logic [15:0] r;
    logic [7:0]  ct;
    logic [2:0]  sz;
    logic        pe, tr;
    int          pick;
    pick = $urandom_range(0, 6);
    case (pick)
      0: r = 16'h07b0;
      1: r = 16'h07b1;
      2: r = 16'h0300;
      3: r = 16'h1020;
      4: r = 16'h0fff;
      default: r = 16'h1000 + 16'($urandom_range(0, 31));
    endcase
    ct = 8'd0; sz = 3'd2; pe = 1'b0; tr = 1'b1;
    case ($urandom_range(0, 11))
      0: ct = 8'($urandom_range(1, 255));
      1: sz = 3'($urandom_range(0, 7));
      2: pe = 1'b1;
      3: begin tr = 1'b0; sz = 3'($urandom_range(0, 7)); end
      default: ;
    endcase
    return {ct, 1'b0, sz, 1'b0, pe, tr, 1'($urandom_range(0, 1)), r};
  endfunction

  initial begin
    int n_busy, we_at;
    repeat (2) tick();
    chk_on = 1;
    chk("rst_busy", busy_o, 0);
    chk("rst_cmderr", cmderr_o, 0);
    chk("rst_ar_en", ar_en_o, 0);
    chk("rst_data0", data0_o, 0);
    reset_ni = 1'b1;
    tick();

    issue(32'h0023_1001, 32'hDEAD_BEEF);
    chk("w_en", ar_en_o, 1);
    chk("w_wr", ar_wr_o, 1);
    chk("w_ad", ar_ad_o, 32'h1001);
    chk("w_do", ar_do_o, 32'hDEAD_BEEF);
    chk("w_busy1", busy_o, 1);
    tick();
    chk("w_en_off", ar_en_o, 0);
    chk("w_busy2", busy_o, 1);
    tick();
    chk("w_busy_low", busy_o, 0);
    chk("w_err", cmderr_o, 0);

    ar_di_i = 32'h0000_0104;
    issue(32'h0022_07b1, 32'h0);
    chk("r_en", ar_en_o, 1);
    chk("r_wr", ar_wr_o, 0);
    chk("r_ad", ar_ad_o, 32'h07b1);
    n_busy = 0;
    we_at = -1;
    for (int i = 0; i < 10; i++) begin
      if (busy_o) n_busy++;
      if (data0_we_o) begin
        we_at = i;
        chk("r_data", data0_o, 32'h104);
      end
      tick();
    end
    chk("r_we_at", we_at, 3);
    chk("r_busy_len", n_busy, 4);

    core_halted_i = 1'b0;
    issue(32'h0022_07b0, 32'h0);
    chk("h_en", ar_en_o, 0);
    chk("h_busy", busy_o, 1);
    tick();
    chk("h_busy0", busy_o, 0);
    chk("h_err", cmderr_o, 4);
    core_halted_i = 1'b1;
    issue(32'h0022_07b0, 32'h0);
    chk("ign_busy", busy_o, 0);
    chk("ign_err", cmderr_o, 4);
    cmderr_clr_i = 1'b1;
    issue(32'h0022_07b0, 32'h0);
    chk("clr_en", ar_en_o, 1);
    chk("clr_err", cmderr_o, 0);
    wait_idle();

    issue(32'h0022_0300, 32'h0);
    tick();
    chk("bad_regno", cmderr_o, 3);
    clear_err();
    issue(32'h0032_07b0, 32'h0);
    tick();
    chk("bad_size", cmderr_o, 2);
    clear_err();
    issue(32'h0122_07b0, 32'h0);
    tick();
    chk("bad_type", cmderr_o, 2);
    clear_err();

    ar_di_i = 32'h5555_AAAA;
    issue(32'h0022_1005, 32'h0);
    tick();
    cmd_valid_i = 1'b1;
    tick();
    chk("bw_err", cmderr_o, 1);
    tick();
    chk("bw_we", data0_we_o, 1);
    chk("bw_data", data0_o, 32'h5555_AAAA);
    wait_idle();
    clear_err();

    issue(32'h0022_1005, 32'h0);
    tick();
    core_halted_i = 1'b0;
    tick();
    chk("hd_busy", busy_o, 1);
    chk("hd_err", cmderr_o, 4);
    chk("hd_we", data0_we_o, 0);
    tick();
    chk("hd_we2", data0_we_o, 0);
    chk("hd_busy0", busy_o, 0);
    core_halted_i = 1'b1;
    clear_err();

    issue(32'h0022_1005, 32'h0);
    tick();
    #2;
    reset_ni = 1'b0;
    #1;
    chk("rs_busy", busy_o, 0);
    chk("rs_en", ar_en_o, 0);
    chk("rs_we", data0_we_o, 0);
    chk("rs_data0", data0_o, 0);
    tick();
    reset_ni = 1'b1;
    tick();

    for (int c = 0; c < 4000; c++) begin
      if (core_halted_i) begin
        if ($urandom_range(0, 29) == 0) core_halted_i = 1'b0;
      end else if ($urandom_range(0, 4) == 0) begin
        core_halted_i = 1'b1;
      end
      ar_di_i = $urandom;
      data0_i = $urandom;
      cmd_i = rand_cmd();
      cmd_valid_i = ($urandom_range(0, 3) == 0);
      cmderr_clr_i = ($urandom_range(0, 7) == 0);
      reset_ni = ($urandom_range(0, 499) != 0);
      @(posedge clk_i);
      #1;
    end
    cmd_valid_i = 1'b0;
    cmderr_clr_i = 1'b0;
    reset_ni = 1'b1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dbg_abstract_cmd_ctrl.md
Name: dbg_abstract_cmd_ctrl

Overview:
Sequences RISC-V debug "Access Register" abstract commands from the debug module onto the core's abstract register access port (en/wr/addr/wdata, plus read-data return).
- Validates each command and checks that the core is halted.
- Drives one register transaction per command and captures read data into data0.
- Maintains busy and sticky cmderr as seen by the debugger.

Parameters:
RD_LATENCY, 1, cycles from ar_en_o (read) to valid ar_di_i; legal range 1-7
GPR_BASE, 16'h1000, regno of x0; GPRs occupy GPR_BASE..GPR_BASE+31
CSR_DCSR, 16'h07b0, dcsr regno
CSR_DPC, 16'h07b1, dpc regno

Ports:
clk_i  in  1  clock
reset_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  one-cycle pulse: debugger wrote the command register
cmd_i  in  32  command word: [31:24] cmdtype, [22:20] aarsize, [18] postexec, [17] transfer, [16] write, [15:0] regno
data0_i  in  32  current data0 value (write source)
data0_o  out  32  read result to load into data0
data0_we_o  out  1  one-cycle load strobe for data0_o
cmderr_clr_i  in  1  clear cmderr to 0
busy_o  out  1  abstract command in progress
cmderr_o  out  3  sticky error: 0 none, 1 busy, 2 not supported, 3 exception, 4 halt/resume
core_halted_i  in  1  core halted status
ar_en_o  out  1  register access enable
ar_wr_o  out  1  1 = write
ar_ad_o  out  16  register number
ar_do_o  out  32  write data
ar_di_i  in  32  read data, valid RD_LATENCY cycles after a read enable

Behaviour:
- Reset (async, reset_ni=0): state IDLE; all outputs 0. Reset mid-command aborts it; no data0_we_o is issued.
- States: IDLE, ACCESS, WAIT, CAPTURE, DONE.
- Acceptance in IDLE on cmd_valid_i:
  - If cmderr_o != 0, the command is ignored: no state change, busy stays 0.
  - Otherwise the checks below apply in priority order, latching the first that fails. A failed check goes to DONE and does not assert ar_en_o.
    - cmdtype != 0, or postexec = 1, or (transfer = 1 and aarsize != 2) -> cmderr 2.
    - core_halted_i = 0 -> cmderr 4.
    - transfer = 1 and regno is outside GPR range, CSR_DCSR and CSR_DPC -> cmderr 3.
  - transfer = 0 with all checks passing -> DONE with no access.
  - Otherwise latch write, regno and data0_i, then go to ACCESS.
- ACCESS (1 cycle):
  - ar_en_o = 1, ar_ad_o = regno, ar_wr_o = write, ar_do_o = latched data0.
  - Write -> DONE. Read -> WAIT.
- WAIT: counter runs RD_LATENCY-1 cycles; a count of 0 means WAIT is skipped. Then CAPTURE.
- CAPTURE (1 cycle): data0_o = ar_di_i, data0_we_o = 1. Then DONE.
- DONE (1 cycle): busy clears at the next edge; return to IDLE.
- busy_o = 1 in every state except IDLE. It rises the cycle after acceptance.
- Latencies from the accept edge to busy low: write 2 cycles; read 3+RD_LATENCY-1 cycles; rejected or no-transfer command 1 cycle.
- core_halted_i falling during ACCESS, WAIT or CAPTURE:
  - Set cmderr 4, suppress data0_we_o, go to DONE.
  - A write already issued in ACCESS is not retracted.
- cmd_valid_i while busy_o = 1: set cmderr 1 if cmderr is 0; the running command completes unaffected.
- cmderr_o is sticky; only cmderr_clr_i or reset clears it.
- cmderr_clr_i in the same cycle as a new error: the error wins.
- cmderr_clr_i together with cmd_valid_i in IDLE: the clear applies first, then the command is evaluated normally.
- ar_* outputs are 0 outside ACCESS.

Test Plan:
- Halted; cmd 0x0023_1001 (write x1) with data0_i = 0xDEADBEEF -> ar_en/ar_wr = 1, ar_ad = 0x1001, ar_do = 0xDEADBEEF in one cycle; busy high 2 cycles; cmderr 0.
- Halted; RD_LATENCY = 2; cmd 0x0022_07b1 (read dpc) with ar_di_i = 0x0000_0104 -> data0_we pulse with data0_o = 0x104 three cycles after the access; busy high 4 cycles.
- Core running; cmd 0x0022_07b0 -> no ar_en; cmderr 4. Next cmd ignored until cmderr_clr_i; after the clear, the same command with core halted succeeds.
- Halted; regno 0x0300 with transfer -> cmderr 3. Separately, aarsize = 3 -> cmderr 2; cmdtype = 1 -> cmderr 2.
- Read in progress, then second cmd_valid_i during WAIT -> cmderr 1; first read still captures correctly.
- During WAIT, drop core_halted_i -> no data0_we, cmderr 4. Separately, assert reset_ni = 0 during WAIT -> busy and all outputs 0 immediately; state IDLE.
